// File: rtl/usb_tx_arb_pkg.sv
// Shared types and constants for the USB IN-data arbiter.
package usb_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        NAK    = 2'd2
    } state_e;

    localparam int MAXP_HS = 512;
    localparam int MAXP_FS = 64;
    localparam int LEN_W   = 12;

endpackage

// File: rtl/usb_tx_arbiter.sv
// Routes the controller's single IN-data interface to one of NUM_EP endpoint sources.
// Define USB_TX_ZLP_EN to send a zero-length packet after a max-size final packet.
module usb_tx_arbiter
    import usb_tx_arb_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int LEN_W  = usb_tx_arb_pkg::LEN_W
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    highspeed_i,
    input  logic [3:0]              endpt_i,
    input  logic                    txact_i,
    input  logic                    txpop_i,
    input  logic                    txpktfin_i,
    output logic [7:0]              txdat_o,
    output logic [LEN_W-1:0]        txdat_len_o,
    output logic                    txcork_o,
    output logic                    txval_o,
    input  logic [NUM_EP*LEN_W-1:0] src_cnt_i,
    input  logic [NUM_EP*8-1:0]     src_dat_i,
    output logic [NUM_EP-1:0]       src_pop_o,
    output logic                    err_overpop_o
);

    localparam int SEL_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    state_e                  state_q, state_d;
    logic                    txact_prev_q;
    logic [SEL_W-1:0]        act_sel_q, act_sel_d;
    logic [LEN_W-1:0]        remaining_q, remaining_d;
    logic [LEN_W-1:0]        txdat_len_q, txdat_len_d;
    logic                    txcork_q, txcork_d;
    logic                    txval_q, txval_d;
    logic                    err_overpop_q, err_overpop_d;
    logic [NUM_EP-1:0]       zlp_pend_q, zlp_pend_d;

    logic [LEN_W-1:0]              maxp;
    logic [NUM_EP-1:0][LEN_W-1:0]  ep_len;
    logic [NUM_EP-1:0]             ep_cork;
    logic [NUM_EP-1:0][7:0]        src_dat;
    logic                          ep_valid;
    logic [SEL_W-1:0]              sel;
    logic                          txact_rise;

`ifdef USB_TX_ZLP_EN
    logic [LEN_W-1:0]        act_len_q, act_len_d;
`else
    logic                    unused_pktfin;
    assign unused_pktfin = txpktfin_i;
`endif

    assign maxp       = highspeed_i ? LEN_W'(MAXP_HS) : LEN_W'(MAXP_FS);
    assign ep_valid   = (endpt_i != 4'd0) && (int'(endpt_i) <= NUM_EP);
    assign sel        = SEL_W'(endpt_i - 4'd1);
    assign txact_rise = txact_i && !txact_prev_q;
    assign src_dat    = src_dat_i;

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        logic [LEN_W-1:0] cnt;
        assign cnt        = src_cnt_i[i*LEN_W +: LEN_W];
        assign ep_len[i]  = (cnt > maxp) ? maxp : cnt;
        assign ep_cork[i] = (cnt == '0) && !zlp_pend_q[i];
    end

    always_comb begin
        state_d       = state_q;
        act_sel_d     = act_sel_q;
        remaining_d   = remaining_q;
        txdat_len_d   = txdat_len_q;
        txcork_d      = txcork_q;
        txval_d       = txval_q;
        err_overpop_d = err_overpop_q;
        zlp_pend_d    = zlp_pend_q;
`ifdef USB_TX_ZLP_EN
        act_len_d     = act_len_q;
`endif
        src_pop_o     = '0;
        txdat_o       = 8'h00;

        case (state_q)
            IDLE: begin
                if (txact_rise) begin
                    if (ep_valid && !txcork_q) begin
                        state_d     = ACTIVE;
                        act_sel_d   = sel;
                        remaining_d = txdat_len_q;
`ifdef USB_TX_ZLP_EN
                        act_len_d   = txdat_len_q;
`endif
                    end else begin
                        state_d = NAK;
                    end
                end
            end
            ACTIVE: begin
                if (remaining_q != '0) begin
                    txdat_o = src_dat[act_sel_q];
                    if (txpop_i) begin
                        // A pop in the reset cycle would be lost by the source's peer.
                        src_pop_o[act_sel_q] = !reset_i;
                        remaining_d          = remaining_q - LEN_W'(1);
                    end
                end else if (txpop_i) begin
                    err_overpop_d = 1'b1;
                end
`ifdef USB_TX_ZLP_EN
                if (txpktfin_i) zlp_pend_d[act_sel_q] = (act_len_q == maxp);
`endif
                if (!txact_i) state_d = IDLE;
            end
            NAK: begin
                if (!txact_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Packet parameters stay frozen for the whole transaction.
        if (state_d != ACTIVE) begin
            if (ep_valid) begin
                txdat_len_d = ep_len[sel];
                txcork_d    = ep_cork[sel];
            end else begin
                txdat_len_d = '0;
                txcork_d    = 1'b1;
            end
            txval_d = !txcork_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            txact_prev_q  <= 1'b0;
            act_sel_q     <= '0;
            remaining_q   <= '0;
            txdat_len_q   <= '0;
            txcork_q      <= 1'b1;
            txval_q       <= 1'b0;
            err_overpop_q <= 1'b0;
            zlp_pend_q    <= '0;
`ifdef USB_TX_ZLP_EN
            act_len_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            txact_prev_q  <= txact_i;
            act_sel_q     <= act_sel_d;
            remaining_q   <= remaining_d;
            txdat_len_q   <= txdat_len_d;
            txcork_q      <= txcork_d;
            txval_q       <= txval_d;
            err_overpop_q <= err_overpop_d;
            zlp_pend_q    <= zlp_pend_d;
`ifdef USB_TX_ZLP_EN
            act_len_q     <= act_len_d;
`endif
        end
    end

    assign txdat_len_o   = txdat_len_q;
    assign txcork_o      = txcork_q;
    assign txval_o       = txval_q;
    assign err_overpop_o = err_overpop_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: FIFO source model plus byte scoreboard.
module tb_usb_tx_arbiter;
    import usb_tx_arb_pkg::*;

    localparam int NUM_EP = 4;
    localparam int LW     = 12;

    logic                 clk = 1'b0;
    logic                 reset_i, highspeed_i, txact_i, txpop_i, txpktfin_i;
    logic [3:0]           endpt_i;
    logic [7:0]           txdat_o;
    logic [LW-1:0]        txdat_len_o;
    logic                 txcork_o, txval_o, err_overpop_o;
    logic [NUM_EP*LW-1:0] src_cnt_i;
    logic [NUM_EP*8-1:0]  src_dat_i;
    logic [NUM_EP-1:0]    src_pop_o;

    always #5 clk = ~clk;

    usb_tx_arbiter #(.NUM_EP(NUM_EP), .LEN_W(LW)) dut (
        .clk_i(clk), .reset_i(reset_i), .highspeed_i(highspeed_i),
        .endpt_i(endpt_i), .txact_i(txact_i), .txpop_i(txpop_i),
        .txpktfin_i(txpktfin_i), .txdat_o(txdat_o), .txdat_len_o(txdat_len_o),
        .txcork_o(txcork_o), .txval_o(txval_o), .src_cnt_i(src_cnt_i),
        .src_dat_i(src_dat_i), .src_pop_o(src_pop_o), .err_overpop_o(err_overpop_o)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cnt  [NUM_EP];
    int         npop [NUM_EP];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] byte_of(input int ep, input int n);
        return 8'((n * 3 + ep * 64 + 1) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < NUM_EP; i++) begin
            src_cnt_i[i*LW +: LW] = LW'(cnt[i]);
            src_dat_i[i*8 +: 8]   = byte_of(i, npop[i]);
        end
    endtask

    task automatic set_cnt(input int ep, input int c);
        cnt[ep] = c;
        apply_src();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Opens a transaction and loads the scoreboard with the bytes the source will hand out.
    task automatic start_txn(input int ep, input int len);
        @(negedge clk);
        txact_i = 1'b1;
        tick(1);
        for (int k = 0; k < len; k++) exp_q.push_back(byte_of(ep, npop[ep] + k));
    endtask

    task automatic end_txn(input logic fin);
        @(negedge clk);
        txact_i    = 1'b0;
        txpktfin_i = fin;
        @(negedge clk);
        txpktfin_i = 1'b0;
    endtask

    task automatic pop(input int ep, input bit exp_pop);
        logic [NUM_EP-1:0] pv;
        logic [7:0]        exp_b;
        @(negedge clk);
        txpop_i = 1'b1;
        #1;
        if (exp_pop) begin
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("pop_vec", 32'(src_pop_o), 32'(1 << ep));
            chk("txdat", 32'(txdat_o), 32'(exp_b));
        end else begin
            chk("no_pop", 32'(src_pop_o), 32'd0);
            chk("txdat_zero", 32'(txdat_o), 32'd0);
        end
        pv = src_pop_o;
        tick(1);
        txpop_i = 1'b0;
        for (int i = 0; i < NUM_EP; i++) if (pv[i]) begin
            cnt[i]--;
            npop[i]++;
        end
        apply_src();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; highspeed_i = 1'b1; endpt_i = 4'd0;
        txact_i = 1'b0; txpop_i = 1'b0; txpktfin_i = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin cnt[i] = 0; npop[i] = 0; end
        apply_src();
        tick(2);
        chk("rst_txdat", 32'(txdat_o), 32'd0);
        chk("rst_len", 32'(txdat_len_o), 32'd0);
        chk("rst_cork", 32'(txcork_o), 32'd1);
        chk("rst_val", 32'(txval_o), 32'd0);
        chk("rst_pop", 32'(src_pop_o), 32'd0);
        chk("rst_err", 32'(err_overpop_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;

        // HS, EP2 holding 700 bytes: one full 512 packet then 188
        endpt_i = 4'd2;
        set_cnt(1, 700);
        tick(2);
        chk("hs_len512", 32'(txdat_len_o), 32'd512);
        chk("hs_cork", 32'(txcork_o), 32'd0);
        chk("hs_val", 32'(txval_o), 32'd1);
        start_txn(1, 512);
        chk("hs_state", 32'(dut.state_q), 32'(ACTIVE));
        for (int k = 0; k < 512; k++) pop(1, 1);
        chk("hs_len_frozen", 32'(txdat_len_o), 32'd512);
        end_txn(1);
        tick(2);
        chk("hs_len188", 32'(txdat_len_o), 32'd188);
        chk("hs_cork2", 32'(txcork_o), 32'd0);
        start_txn(1, 188);
        for (int k = 0; k < 188; k++) pop(1, 1);
        end_txn(1);
        tick(2);
        chk("hs_empty_cork", 32'(txcork_o), 32'd1);
        chk("hs_empty_val", 32'(txval_o), 32'd0);
        chk("hs_empty_len", 32'(txdat_len_o), 32'd0);

        // FS, EP1 exactly one max-size packet
        highspeed_i = 1'b0;
        endpt_i = 4'd1;
        set_cnt(0, 64);
        tick(2);
        chk("fs_len64", 32'(txdat_len_o), 32'd64);
        start_txn(0, 64);
        for (int k = 0; k < 64; k++) pop(0, 1);
        end_txn(1);
        tick(2);
`ifdef USB_TX_ZLP_EN
        chk("zlp_cork", 32'(txcork_o), 32'd0);
        chk("zlp_len", 32'(txdat_len_o), 32'd0);
        chk("zlp_val", 32'(txval_o), 32'd1);
        start_txn(0, 0);
        pop(0, 0);
        end_txn(1);
        tick(2);
        chk("zlp_done_cork", 32'(txcork_o), 32'd1);
`else
        chk("nozlp_cork", 32'(txcork_o), 32'd1);
        chk("nozlp_val", 32'(txval_o), 32'd0);
`endif
        chk("fs_err_clear", 32'(err_overpop_o), 32'd0);

        // Invalid endpoints 0 and 7 must NAK without touching any source
        set_cnt(0, 5);
        set_cnt(3, 5);
        for (int t = 0; t < 2; t++) begin
            endpt_i = (t == 0) ? 4'd0 : 4'd7;
            tick(2);
            chk("inv_cork", 32'(txcork_o), 32'd1);
            chk("inv_len", 32'(txdat_len_o), 32'd0);
            chk("inv_val", 32'(txval_o), 32'd0);
            @(negedge clk);
            txact_i = 1'b1;
            tick(1);
            chk("inv_nak", 32'(dut.state_q), 32'(NAK));
            pop(0, 0);
            pop(3, 0);
            @(negedge clk);
            txact_i = 1'b0;
            tick(1);
            chk("inv_idle", 32'(dut.state_q), 32'(IDLE));
            chk("inv_err", 32'(err_overpop_o), 32'd0);
        end

        // EP3, 10 bytes, 11 pops: the last one is an overpop
        highspeed_i = 1'b1;
        endpt_i = 4'd3;
        set_cnt(2, 10);
        tick(2);
        chk("op_len", 32'(txdat_len_o), 32'd10);
        start_txn(2, 10);
        for (int k = 0; k < 10; k++) pop(2, 1);
        pop(2, 0);
        chk("op_err", 32'(err_overpop_o), 32'd1);
        end_txn(0);
        tick(3);
        chk("op_err_sticky", 32'(err_overpop_o), 32'd1);

        // EP4 grows 5 -> 300 mid-packet; length stays 5
        endpt_i = 4'd4;
        set_cnt(3, 5);
        tick(2);
        chk("grow_len5", 32'(txdat_len_o), 32'd5);
        start_txn(3, 5);
        set_cnt(3, 300);
        for (int k = 0; k < 5; k++) pop(3, 1);
        pop(3, 0);
        chk("grow_frozen", 32'(txdat_len_o), 32'd5);
        end_txn(0);
        tick(2);
        chk("grow_len295", 32'(txdat_len_o), 32'd295);

        // Reset after 3 of 20 pops
        highspeed_i = 1'b0;
        endpt_i = 4'd1;
        set_cnt(0, 20);
        tick(2);
        chk("rr_len20", 32'(txdat_len_o), 32'd20);
        start_txn(0, 20);
        for (int k = 0; k < 3; k++) pop(0, 1);
        exp_q.delete();
        @(negedge clk);
        reset_i = 1'b1;
        txpop_i = 1'b1;
        #1;
        chk("rr_pop_in_rst", 32'(src_pop_o), 32'd0);
        tick(1);
        chk("rr_txdat", 32'(txdat_o), 32'd0);
        chk("rr_len", 32'(txdat_len_o), 32'd0);
        chk("rr_cork", 32'(txcork_o), 32'd1);
        chk("rr_val", 32'(txval_o), 32'd0);
        chk("rr_pop", 32'(src_pop_o), 32'd0);
        chk("rr_err", 32'(err_overpop_o), 32'd0);
        chk("rr_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        reset_i = 1'b0;
        txact_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rr_no_more_pop", 32'(src_pop_o), 32'd0);
        end
        txpop_i = 1'b0;
        tick(2);
        chk("rr_len17", 32'(txdat_len_o), 32'd17);
        chk("rr_cork_after", 32'(txcork_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
# usb_tx_arbiter

Shares the USB device controller's single IN-data interface (txdat/txcork/txdat_len/txpop/txact) between up to NUM_EP streaming sources, one per IN endpoint 1..NUM_EP. Per transaction, it selects the source matching the controller's endpoint number and computes packet length and cork. It snapshots the length at packet start, routes and counts byte pops, and tracks zero-length-packet termination. It sits between the controller top and the endpoint FIFOs (UART/PWM bridge, ADC stream), all in the PHY_CLKOUT domain.

## Interface
Parameters:
- NUM_EP, 4, number of IN sources; source i serves endpoint i+1
- LEN_W, 12, byte-count width (matches txdat_len)

Ports:
- clk_i  in  1  PHY_CLKOUT (60 MHz); one clock
- reset_i  in  1  synchronous, active-high reset
- highspeed_i  in  1  1 = HS (max packet 512), 0 = FS (max packet 64)
- endpt_i  in  4  endpoint number from the controller
- txact_i  in  1  IN transaction active
- txpop_i  in  1  controller consumes one byte this cycle
- txpktfin_i  in  1  one-cycle pulse: packet completed
- txdat_o  out  8  byte presented to the controller
- txdat_len_o  out  LEN_W  length of the next/current packet
- txcork_o  out  1  1 = nothing to send (controller NAKs)
- txval_o  out  1  packet armed for the selected endpoint
- src_cnt_i  in  NUM_EP*LEN_W  bytes available per source, packed; slice i = source i
- src_dat_i  in  NUM_EP*8  first-word-fall-through head byte per source
- src_pop_o  out  NUM_EP  one-cycle pop per source
- err_overpop_o  out  1  sticky: pop requested with zero bytes remaining

## Operation
- MAXP = highspeed_i ? 512 : 64.
- sel = endpt_i-1 when 1 ≤ endpt_i ≤ NUM_EP; otherwise the endpoint is invalid.
- **IDLE** state, recomputed and registered every cycle:
  - txdat_len_o = min(src_cnt[sel], MAXP).
  - txcork_o = (src_cnt[sel]==0) && !zlp_pend[sel].
  - txval_o = !txcork_o.
  - Invalid endpoint: txcork_o=1, txdat_len_o=0, txval_o=0.
- IDLE→**ACTIVE** on the rising edge of txact_i (txact_i=1, prev=0) with a valid endpoint and txcork_o=0:
  - Latch act_sel=sel, act_len=txdat_len_o, remaining=act_len.
  - Outputs are frozen while ACTIVE.
- txact_i rising with txcork_o=1 or an invalid endpoint: go to **NAK**; no pops. Return to IDLE when txact_i falls.
- ACTIVE, txpop_i=1:
  - remaining>0: src_pop_o[act_sel]=1 (same cycle, combinational); remaining decrements.
  - remaining==0: no pop; err_overpop_o set; txdat_o=0.
- txdat_o = src_dat[act_sel] while ACTIVE and remaining>0; otherwise 0x00.
- ACTIVE→IDLE when txact_i falls.
- If txpktfin_i occurred during ACTIVE:
  - zlp_pend[act_sel] = (act_len==MAXP) (with the macro enabled).
  - act_len==0 clears zlp_pend[act_sel].
- No replay of popped bytes; retry data integrity is the controller's responsibility.
- err_overpop_o clears only on reset_i.

## Timing
- Reset values:
  - txdat_o=0, txdat_len_o=0, txcork_o=1, txval_o=0, src_pop_o=0, err_overpop_o=0.
  - State=IDLE; zlp_pend all 0; remaining=0.
- txcork_o, txdat_len_o and txval_o lag endpt_i and src_cnt_i by 1 cycle.
- src_pop_o and txdat_o follow txpop_i with 0 cycles of latency (combinational).
- src_cnt_i changing during ACTIVE has no effect on act_len.
- txpktfin_i and txact_i falling in the same cycle: the ZLP update is applied.
- reset_i mid-ACTIVE: immediate return to IDLE; no further pops; pending ZLPs lost.
- Remaining counter never wraps: it saturates at 0.

## Configuration
- USB_TX_ZLP_EN defined:
  - zlp_pend is tracked.
  - An endpoint whose last completed packet was exactly MAXP and whose source is now empty is offered uncorked with txdat_len_o=0, exactly once.
- USB_TX_ZLP_EN undefined:
  - zlp_pend is tied to 0.
  - An empty source is always corked.

## Structure
- Package usb_tx_arb_pkg:
  - state enum {IDLE, ACTIVE, NAK}
  - constants MAXP_HS=512, MAXP_FS=64, LEN_W=12
- Single module; no sub-module. The per-endpoint min/cork logic is a generate loop.

## Test plan
- HS, EP2 src_cnt=700; txact with 512 pops → txdat_len_o=512, 512 pops on src_pop_o[1], data in FIFO order; then txdat_len_o=188.
- FS, EP1 src_cnt=64; packet of 64 with txpktfin_i; source empty:
  - with macro: txcork_o=0, txdat_len_o=0; after the ZLP completes, txcork_o=1.
  - without macro: txcork_o=1 immediately.
- endpt_i=0 or 7 with NUM_EP=4, txact_i pulsed → txcork_o=1, no src_pop_o, state NAK then IDLE.
- EP3 act_len=10, 11 txpop_i pulses → 10 pops, err_overpop_o=1 and stays 1, txdat_o=0 on the 11th pop.
- src_cnt increases 5→300 mid-ACTIVE → only 5 pops; next IDLE txdat_len_o=295 (HS).
- reset_i asserted after 3 of 20 pops → all outputs at reset values next cycle, no further pops.
